// File: rtl/pcw_dn_sink.sv
// Download sink: edge-detects dn_wr bytes into a FIFO, writes them to RAM over req/ack,
// holds the CPU during a download and pulses cpu_start. Optional macro: DN_CHECKSUM_EN.
module pcw_dn_sink #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_go,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [15:0] execute_addr,
  input  logic        execute_enable,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        cpu_start,
  output logic [15:0] cpu_start_addr,
  output logic        overflow,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_START} state_t;

  state_t        state_reg, state_next;
  logic          wr_q_reg;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          mem_req_reg;
  logic [15:0]   mem_addr_reg;
  logic [7:0]    mem_din_reg;
  logic          exec_latch_reg;
  logic [15:0]   start_addr_reg;
  logic          overflow_reg;
  logic [16:0]   byte_count_reg;

  logic wr_rise, load_out, push, drop, ack_ok, start_clear, exec_ok;

  assign wr_rise     = dn_wr & ~wr_q_reg;
  // The head moves into the output register whenever no request is outstanding,
  // so a full FIFO only rejects a byte while a request is also in flight.
  assign load_out    = (count_reg != '0) & ~mem_req_reg;
  assign push        = (state_reg == S_LOAD) & wr_rise & ((count_reg != CNT_FULL) | load_out);
  assign drop        = (state_reg == S_LOAD) & wr_rise & ~push;
  assign ack_ok      = mem_ack & mem_req_reg;
  assign start_clear = (state_reg == S_IDLE) & dn_go;
  assign exec_ok     = execute_enable & ((state_reg == S_LOAD) | (state_reg == S_DRAIN));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (dn_go) state_next = S_LOAD;
      S_LOAD:  if (!dn_go) state_next = S_DRAIN;
      S_DRAIN: if ((count_reg == '0) && !mem_req_reg)
                 state_next = exec_latch_reg ? S_START : S_IDLE;
      S_START: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr_reg] <= {dn_addr, dn_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      wr_q_reg       <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      exec_latch_reg <= 1'b0;
      start_addr_reg <= '0;
      overflow_reg   <= 1'b0;
      byte_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wr_q_reg  <= dn_wr;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load_out) begin
        rd_ptr_reg                   <= rd_ptr_reg + 1'b1;
        {mem_addr_reg, mem_din_reg}  <= fifo_mem[rd_ptr_reg];
        mem_req_reg                  <= 1'b1;
      end else if (ack_ok) begin
        mem_req_reg <= 1'b0;
      end
      case ({push, load_out})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (start_clear) begin
        byte_count_reg <= '0;
        overflow_reg   <= 1'b0;
        exec_latch_reg <= 1'b0;
      end else begin
        if (push) byte_count_reg <= byte_count_reg + 1'b1;
        if (drop) overflow_reg <= 1'b1;
        if (exec_ok) begin
          exec_latch_reg <= 1'b1;
          start_addr_reg <= execute_addr;
        end
      end
    end
  end

`ifdef DN_CHECKSUM_EN
  logic [15:0] checksum_reg;
  always_ff @(posedge clk_sys) begin
    if (reset || start_clear) checksum_reg <= '0;
    else if (push)            checksum_reg <= checksum_reg + {8'h00, dn_data};
  end
  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign mem_req        = mem_req_reg;
  assign mem_addr       = mem_addr_reg;
  assign mem_din        = mem_din_reg;
  assign cpu_hold       = (state_reg != S_IDLE);
  assign cpu_start      = (state_reg == S_START);
  assign cpu_start_addr = start_addr_reg;
  assign overflow       = overflow_reg;
  assign byte_count     = byte_count_reg;

endmodule

// File: tb/tb_pcw_dn_sink.sv
// Randomized scoreboard bench for pcw_dn_sink against a transaction-level download model.
module tb_pcw_dn_sink;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_START = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dn_go = 1'b0, dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic [15:0] execute_addr = '0;
  logic        execute_enable = 1'b0;
  logic        mem_req, mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        cpu_hold, cpu_start, overflow;
  logic [15:0] cpu_start_addr, checksum;
  logic [16:0] byte_count;

  pcw_dn_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk), .reset(reset), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .execute_addr(execute_addr), .execute_enable(execute_enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_start_addr(cpu_start_addr),
    .overflow(overflow), .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ack_delay = 1;          // negative: random 0..4 per request
  bit spur_en = 1'b0;
  bit ack_real = 1'b0;
  int start_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes in flight = accepted minus acknowledged; capacity is DEPTH+1.
  int          m_phase = P_IDLE, m_inflight = 0, pre_if;
  bit          m_wr_prev = 0, m_latch = 0, m_ovf = 0, rise, pre_latch;
  logic [16:0] m_bc = '0;
  logic [15:0] m_cs = '0, m_saddr = '0;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_phase = P_IDLE; m_inflight = 0; m_wr_prev = 0; m_latch = 0; m_ovf = 0;
      m_bc = '0; m_cs = '0; m_saddr = '0; exp_q.delete();
    end else begin
      rise = dn_wr && !m_wr_prev;
      pre_if = m_inflight;
      pre_latch = m_latch;
      case (m_phase)
        P_IDLE: if (dn_go) begin
          m_bc = '0; m_cs = '0; m_ovf = 0; m_latch = 0; m_phase = P_LOAD;
        end
        P_LOAD, P_DRAIN: begin
          if (m_phase == P_LOAD && rise) begin
            if (pre_if < DEPTH + 1) begin
              exp_q.push_back({dn_addr, dn_data});
              m_inflight++;
              m_bc = m_bc + 17'd1;
              m_cs = m_cs + 16'(dn_data);
            end else m_ovf = 1;
          end
          if (execute_enable) begin m_latch = 1; m_saddr = execute_addr; end
          if (m_phase == P_LOAD) begin
            if (!dn_go) m_phase = P_DRAIN;
          end else if (pre_if == 0) m_phase = pre_latch ? P_START : P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
      if (ack_real) m_inflight--;
      m_wr_prev = dn_wr;
    end
  end

  // Monitor: per-cycle output checks, write scoreboard and memory responder.
  bit          req_seen = 0;
  int          wait_cnt = 0;
  logic [23:0] cur;
  always @(negedge clk) begin
    if (!reset) begin
      chk("cpu_hold", 32'(cpu_hold), 32'(m_phase != P_IDLE));
      chk("cpu_start", 32'(cpu_start), 32'(m_phase == P_START));
      chk("byte_count", 32'(byte_count), 32'(m_bc));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("start_addr", 32'(cpu_start_addr), 32'(m_saddr));
`ifdef DN_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(m_cs));
`else
      chk("checksum", 32'(checksum), 32'd0);
`endif
    end
    if (cpu_start) start_cnt++;
    mem_ack = 1'b0;
    ack_real = 1'b0;
    if (mem_req) begin
      if (!req_seen) begin
        req_seen = 1;
        if (exp_q.size() == 0) chk("unexpected_write", {8'h0, mem_addr, mem_din}, 32'hFFFFFFFF);
        else begin
          cur = exp_q.pop_front();
          chk("write", {8'h0, mem_addr, mem_din}, {8'h0, cur});
        end
        wait_cnt = (ack_delay < 0) ? int'($urandom_range(0, 4)) : ack_delay;
      end else chk("write_stable", {8'h0, mem_addr, mem_din}, {8'h0, cur});
      if (wait_cnt == 0) begin mem_ack = 1'b1; ack_real = 1'b1; end
      else wait_cnt--;
    end else begin
      req_seen = 0;
      if (spur_en && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(logic [15:0] a, logic [7:0] d, int hold, int gap);
    dn_addr = a; dn_data = d; dn_wr = 1'b1;
    cyc(hold);
    dn_wr = 1'b0;
    cyc(gap);
  endtask

  task automatic pulse_exec(logic [15:0] a);
    execute_addr = a; execute_enable = 1'b1;
    cyc(1);
    execute_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_phase != P_IDLE || exp_q.size() != 0) && n < 3000) begin cyc(1); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
    end
    cyc(2);
  endtask

  int s0, n;
  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_hold", 32'(cpu_hold), 0);

    // Three bytes, ack one cycle after each request, then execute at 0x0100.
    ack_delay = 1; s0 = start_cnt;
    dn_go = 1'b1; cyc(2);
    send_byte(16'h0000, 8'hF3, 3, 2);
    send_byte(16'h0001, 8'h31, 3, 2);
    send_byte(16'h0002, 8'h00, 3, 2);
    pulse_exec(16'h0100);
    dn_go = 1'b0;
    wait_idle();
    chk("t1_count", 32'(byte_count), 3);
    chk("t1_starts", 32'(start_cnt - s0), 1);
    chk("t1_addr", 32'(cpu_start_addr), 32'h0100);
    chk("t1_hold", 32'(cpu_hold), 0);
`ifdef DN_CHECKSUM_EN
    chk("t1_checksum", 32'(checksum), 32'h0124);
`endif

    // Ack held off: 6 edges, only DEPTH+1 fit.
    ack_delay = 20;
    dn_go = 1'b1; cyc(2);
    for (int i = 0; i < 6; i++) send_byte(16'(16'h0200 + i), 8'(8'hA0 + i), 2, 1);
    chk("t2_overflow", 32'(overflow), 1);
    chk("t2_count", 32'(byte_count), 5);
    dn_go = 1'b0;
    wait_idle();

    // Long dn_wr pulses push once per edge.
    ack_delay = -1;
    dn_go = 1'b1; cyc(2);
    for (int i = 0; i < 3; i++) send_byte(16'(16'h0300 + i), 8'($urandom), 8, 2);
    chk("t3_count", 32'(byte_count), 3);
    dn_go = 1'b0;
    wait_idle();

    // Execute coincides with dn_go falling while bytes are queued.
    ack_delay = 6; s0 = start_cnt;
    dn_go = 1'b1; cyc(2);
    for (int i = 0; i < 3; i++) send_byte(16'(16'h0400 + i), 8'(i + 1), 1, 1);
    execute_addr = 16'h1234; execute_enable = 1'b1; dn_go = 1'b0;
    cyc(1);
    execute_enable = 1'b0;
    chk("t4_hold_pending", 32'(cpu_hold), 1);
    wait_idle();
    chk("t4_starts", 32'(start_cnt - s0), 1);
    chk("t4_addr", 32'(cpu_start_addr), 32'h1234);

    // Reset while a request is outstanding.
    ack_delay = 10;
    dn_go = 1'b1; cyc(2);
    pulse_exec(16'hBEEF);
    send_byte(16'h0500, 8'h55, 1, 1);
    n = 0;
    while (!mem_req && n < 20) begin cyc(1); n++; end
    chk("t5_req_seen", 32'(mem_req), 1);
    reset = 1'b1; dn_go = 1'b0;
    cyc(1);
    chk("t5_outputs", {mem_req, cpu_hold, cpu_start, overflow, 28'h0},
        {1'b0, 1'b0, 1'b0, 1'b0, 28'h0});
    chk("t5_addr_data", {8'h0, mem_addr, mem_din}, 0);
    chk("t5_start_addr", 32'(cpu_start_addr), 0);
    chk("t5_count_sum", {byte_count[15:0], checksum}, 0);
    reset = 1'b0;
    cyc(1);
    ack_delay = 0;
    dn_go = 1'b1; cyc(2);
    send_byte(16'h0600, 8'h01, 2, 1);
    send_byte(16'h0601, 8'h02, 2, 1);
    chk("t5_recount", 32'(byte_count), 2);
    dn_go = 1'b0;
    wait_idle();

    // No execute: back to IDLE without a start pulse.
    s0 = start_cnt; ack_delay = 2;
    dn_go = 1'b1; cyc(2);
    send_byte(16'h0700, 8'h77, 2, 2);
    dn_go = 1'b0;
    wait_idle();
    chk("t6_starts", 32'(start_cnt - s0), 0);
    chk("t6_hold", 32'(cpu_hold), 0);

    // Randomized downloads, spurious acks, stray edges outside the window.
    ack_delay = -1; spur_en = 1'b1;
    for (int d = 0; d < 25; d++) begin
      if ($urandom_range(0, 3) == 0) send_byte(16'($urandom), 8'($urandom), 1, 1);
      if ($urandom_range(0, 3) == 0) pulse_exec(16'($urandom));
      dn_go = 1'b1;
      cyc($urandom_range(1, 3));
      for (int b = 0; b < int'($urandom_range(1, 8)); b++) begin
        send_byte(16'($urandom), 8'($urandom), $urandom_range(1, 4), $urandom_range(1, 3));
        if ($urandom_range(0, 4) == 0) pulse_exec(16'($urandom));
      end
      if ($urandom_range(0, 1) == 0) execute_enable = 1'b1;
      execute_addr = 16'($urandom);
      dn_go = 1'b0;
      cyc(1);
      execute_enable = 1'b0;
      if ($urandom_range(0, 2) == 0) pulse_exec(16'($urandom));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
